// File: rtl/pong_pkg.sv
// Shared encodings for the pong display path: perimeter edges, walk direction
// and palette constants, plus small helpers for the perimeter walk.
package pong_pkg;

  typedef enum logic [1:0] {
    E_TOP    = 2'd0,
    E_RIGHT  = 2'd1,
    E_BOTTOM = 2'd2,
    E_LEFT   = 2'd3
  } edge_e;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  localparam logic [2:0] COLOR_GREEN = 3'b010;

  // Edge reached after the corner at the end of edge e for the given direction.
  function automatic edge_e next_edge(input edge_e e, input logic dir);
    logic [1:0] n;
    n = (dir == DIR_CW) ? 2'(e + 2'd1) : 2'(e - 2'd1);
    return edge_e'(n);
  endfunction

  // TOP/BOTTOM travel along x, RIGHT/LEFT along y.
  function automatic logic edge_is_x(input edge_e e);
    return (e == E_TOP) || (e == E_BOTTOM);
  endfunction

  // Clockwise, TOP and RIGHT move towards larger coordinates; CCW flips it.
  function automatic logic edge_goes_up(input edge_e e, input logic dir);
    return ((e == E_TOP) || (e == E_RIGHT)) ^ dir;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Move-strobe prescaler: one strobe per DIV enabled cycles, held at the
// terminal count while the consumer is not ready.
module tick_divider #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic ready_i,
  output logic move_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  assign move_o  = en_i && at_last && ready_i;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (!at_last) begin
        cnt_d = cnt_q + 1'b1;
      end else if (ready_i) begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rect_path_tracer.sv
// Walks the perimeter of a fixed rectangle one point per move, CW or CCW,
// with saturating steps, corner turns, lap counting and valid/ready pacing.
module rect_path_tracer
  import pong_pkg::*;
#(
  parameter int COORD_W = 8,
  parameter int X_MIN   = 5,
  parameter int X_MAX   = 105,
  parameter int Y_MIN   = 15,
  parameter int Y_MAX   = 115,
  parameter int STEP    = 1,
  parameter int DIV     = 1,
  parameter int LAP_W   = 8,
  parameter int COLOR_W = 3,
  parameter logic [COLOR_W-1:0] COLOR = COLOR_GREEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               dir,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [COORD_W-1:0] CounterX,
  output logic [COORD_W-1:0] CounterY,
  output logic [COLOR_W-1:0] color,
  output logic [1:0]         edge_id,
  output logic               lap_done,
  output logic [LAP_W-1:0]   lap_cnt
);

  localparam int XW = COORD_W + 1;
  localparam logic [COORD_W-1:0] XMIN_C = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] XMAX_C = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YMIN_C = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] YMAX_C = COORD_W'(Y_MAX);

  // One extra bit of headroom so pos+STEP / lo+STEP never wrap before clamping.
  function automatic logic [COORD_W-1:0] sat_step(
    input logic [COORD_W-1:0] pos,
    input logic               up,
    input logic [COORD_W-1:0] lo,
    input logic [COORD_W-1:0] hi
  );
    logic [XW-1:0] w;
    if (up) begin
      w = {1'b0, pos} + XW'(STEP);
      if (w > {1'b0, hi}) w = {1'b0, hi};
    end else begin
      if ({1'b0, pos} < ({1'b0, lo} + XW'(STEP))) w = {1'b0, lo};
      else w = {1'b0, pos} - XW'(STEP);
    end
    return w[COORD_W-1:0];
  endfunction

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  edge_e              edge_q, edge_d;
  logic               valid_q;
  logic               lap_done_q, lap_done_d;
  logic [LAP_W-1:0]   lap_q, lap_d;
  logic [COLOR_W-1:0] color_q;
  logic               move;

  logic               cur_up, cur_x, at_end, mv_up, mv_x;
  logic [COORD_W-1:0] cur_pos, cur_end;
  edge_e              mv_edge;

  tick_divider #(
    .DIV(DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en),
    .ready_i(out_ready),
    .move_o (move)
  );

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    edge_d     = edge_q;
    lap_d      = lap_q;
    lap_done_d = 1'b0;

    cur_up  = edge_goes_up(edge_q, dir);
    cur_x   = edge_is_x(edge_q);
    cur_pos = cur_x ? x_q : y_q;
    cur_end = cur_up ? (cur_x ? XMAX_C : YMAX_C) : (cur_x ? XMIN_C : YMIN_C);
    at_end  = (cur_pos == cur_end);

    // Sitting on the corner: turn and step along the new edge in one move.
    mv_edge = at_end ? next_edge(edge_q, dir) : edge_q;
    mv_up   = edge_goes_up(mv_edge, dir);
    mv_x    = edge_is_x(mv_edge);

    if (move) begin
      edge_d = mv_edge;
      if (mv_x) x_d = sat_step(x_q, mv_up, XMIN_C, XMAX_C);
      else      y_d = sat_step(y_q, mv_up, YMIN_C, YMAX_C);
      if ((x_d == XMIN_C) && (y_d == YMIN_C)) begin
        lap_done_d = 1'b1;
        lap_d      = lap_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q        <= XMIN_C;
      y_q        <= YMIN_C;
      edge_q     <= E_TOP;
      valid_q    <= 1'b0;
      lap_done_q <= 1'b0;
      lap_q      <= '0;
      color_q    <= COLOR;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      edge_q     <= edge_d;
      valid_q    <= en;
      lap_done_q <= lap_done_d;
      lap_q      <= lap_d;
      color_q    <= COLOR;
    end
  end

  assign out_valid = valid_q;
  assign CounterX  = x_q;
  assign CounterY  = y_q;
  assign edge_id   = edge_q;
  assign lap_done  = lap_done_q;
  assign lap_cnt   = lap_q;
  assign color     = color_q;

endmodule

// File: tb/tb_rect_path_tracer.sv
// Directed bench: default walk/backpressure/direction/async reset on one
// instance, STEP=30 and DIV=4 variants on two more.
module tb_rect_path_tracer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic rst_a = 1'b1, en_a = 1'b0, dir_a = 1'b0, rdy_a = 1'b1;
  logic val_a, ld_a;
  logic [7:0] x_a, y_a, lap_a;
  logic [2:0] col_a;
  logic [1:0] edg_a;

  // Instance S: STEP = 30
  logic rst_s = 1'b1, en_s = 1'b0, dir_s = 1'b0, rdy_s = 1'b1;
  logic val_s, ld_s;
  logic [7:0] x_s, y_s, lap_s;
  logic [2:0] col_s;
  logic [1:0] edg_s;

  // Instance D: DIV = 4
  logic rst_d = 1'b1, en_d = 1'b0, dir_d = 1'b0, rdy_d = 1'b1;
  logic val_d, ld_d;
  logic [7:0] x_d, y_d, lap_d;
  logic [2:0] col_d;
  logic [1:0] edg_d;

  rect_path_tracer u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .dir(dir_a), .out_ready(rdy_a),
    .out_valid(val_a), .CounterX(x_a), .CounterY(y_a), .color(col_a),
    .edge_id(edg_a), .lap_done(ld_a), .lap_cnt(lap_a)
  );

  rect_path_tracer #(.STEP(30)) u_s (
    .clk(clk), .rst(rst_s), .en(en_s), .dir(dir_s), .out_ready(rdy_s),
    .out_valid(val_s), .CounterX(x_s), .CounterY(y_s), .color(col_s),
    .edge_id(edg_s), .lap_done(ld_s), .lap_cnt(lap_s)
  );

  rect_path_tracer #(.DIV(4)) u_d (
    .clk(clk), .rst(rst_d), .en(en_d), .dir(dir_d), .out_ready(rdy_d),
    .out_valid(val_d), .CounterX(x_d), .CounterY(y_d), .color(col_d),
    .edge_id(edg_d), .lap_done(ld_d), .lap_cnt(lap_d)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int   n;      // cycles to run
    logic rdy;
    logic dir;
    int   x;
    int   y;
    int   edg;
    int   lap;
    int   pulses; // lap_done pulses expected within the segment
  } seg_t;

  typedef struct {
    int x;
    int y;
    int edg;
  } pt_t;

  seg_t segs[11];
  pt_t  spts[9];
  int   dx[16];

  initial begin
    segs[0]  = '{100, 1'b1, 1'b0, 105,  15, 0, 0, 0};
    segs[1]  = '{  1, 1'b1, 1'b0, 105,  16, 1, 0, 0};
    segs[2]  = '{299, 1'b1, 1'b0,   5,  15, 3, 1, 1};
    segs[3]  = '{ 15, 1'b1, 1'b0,  20,  15, 0, 1, 0};
    segs[4]  = '{  5, 1'b0, 1'b0,  20,  15, 0, 1, 0};
    segs[5]  = '{  1, 1'b1, 1'b0,  21,  15, 0, 1, 0};
    segs[6]  = '{ 29, 1'b1, 1'b0,  50,  15, 0, 1, 0};
    segs[7]  = '{  1, 1'b1, 1'b1,  49,  15, 0, 1, 0};
    segs[8]  = '{ 44, 1'b1, 1'b1,   5,  15, 0, 2, 1};
    segs[9]  = '{  1, 1'b1, 1'b1,   5,  16, 3, 2, 0};
    segs[10] = '{254, 1'b1, 1'b1, 105,  60, 1, 2, 0};

    spts[0] = '{ 35,  15, 0};
    spts[1] = '{ 65,  15, 0};
    spts[2] = '{ 95,  15, 0};
    spts[3] = '{105,  15, 0};
    spts[4] = '{105,  45, 1};
    spts[5] = '{105,  75, 1};
    spts[6] = '{105, 105, 1};
    spts[7] = '{105, 115, 1};
    spts[8] = '{ 75, 115, 2};

    // DIV=4 x after cycle c; en low for cycles 9..11 pushes the 3rd move to 15
    dx[0] = 5;
    for (int c = 1; c <= 15; c++) dx[c] = (c < 4) ? 5 : (c < 8) ? 6 : (c < 15) ? 7 : 8;

    // Asynchronous reset of all instances
    #1;
    rst_a = 1'b0; rst_s = 1'b0; rst_d = 1'b0;
    #1;
    check("rst_x",     int'(x_a),   5);
    check("rst_y",     int'(y_a),   15);
    check("rst_edge",  int'(edg_a), 0);
    check("rst_lap",   int'(lap_a), 0);
    check("rst_valid", int'(val_a), 0);
    check("rst_ldone", int'(ld_a),  0);
    check("rst_color", int'(col_a), 2);
    check("rst_s_x",   int'(x_s),   5);
    check("rst_d_y",   int'(y_d),   15);
    $display("[TB] reset: A=(%0d,%0d) edge %0d lap %0d valid %0d", x_a, y_a, edg_a, lap_a, val_a);
    tick();
    rst_a = 1'b1; rst_s = 1'b1; rst_d = 1'b1;

    // Instance A: segment table
    en_a = 1'b1;
    for (int i = 0; i < 11; i++) begin
      int pulses;
      pulses = 0;
      rdy_a = segs[i].rdy;
      dir_a = segs[i].dir;
      for (int k = 0; k < segs[i].n; k++) begin
        tick();
        if (ld_a) pulses++;
      end
      check($sformatf("seg%0d_x", i),      int'(x_a),   segs[i].x);
      check($sformatf("seg%0d_y", i),      int'(y_a),   segs[i].y);
      check($sformatf("seg%0d_edge", i),   int'(edg_a), segs[i].edg);
      check($sformatf("seg%0d_lap", i),    int'(lap_a), segs[i].lap);
      check($sformatf("seg%0d_pulses", i), pulses,      segs[i].pulses);
      check($sformatf("seg%0d_valid", i),  int'(val_a), 1);
      $display("[TB] seg %0d: %0d cycles rdy=%0d dir=%0d -> (%0d,%0d) edge %0d lap %0d pulses %0d",
               i, segs[i].n, segs[i].rdy, segs[i].dir, x_a, y_a, edg_a, lap_a, pulses);
    end

    // Async reset mid-cycle at (105,60), away from any clock edge
    #3;
    rst_a = 1'b0;
    #1;
    check("arst_x",     int'(x_a),   5);
    check("arst_y",     int'(y_a),   15);
    check("arst_edge",  int'(edg_a), 0);
    check("arst_lap",   int'(lap_a), 0);
    check("arst_valid", int'(val_a), 0);
    $display("[TB] async reset: (%0d,%0d) edge %0d lap %0d valid %0d", x_a, y_a, edg_a, lap_a, val_a);
    en_a = 1'b0;
    tick();
    rst_a = 1'b1;

    // Instance S: STEP = 30 clockwise
    en_s = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("step%0d_x", i),    int'(x_s),   spts[i].x);
      check($sformatf("step%0d_y", i),    int'(y_s),   spts[i].y);
      check($sformatf("step%0d_edge", i), int'(edg_s), spts[i].edg);
      $display("[TB] step move %0d: (%0d,%0d) edge %0d", i + 1, x_s, y_s, edg_s);
    end
    en_s = 1'b0;

    // Instance D: DIV = 4 with an en gap
    for (int c = 1; c <= 15; c++) begin
      logic e;
      e = !((c >= 9) && (c <= 11));
      en_d = e;
      tick();
      check($sformatf("div_c%0d_x", c),     int'(x_d),   dx[c]);
      check($sformatf("div_c%0d_valid", c), int'(val_d), int'(e));
      $display("[TB] div cycle %0d: en=%0d x=%0d valid=%0d", c, e, x_d, val_d);
    end
    en_d = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rect_path_tracer.md
Name: rect_path_tracer

Overview:
- Parametrised successor to the fixed-rectangle perimeter counter used to drive sprite and border positions on the VGA pong display.
- Walks the perimeter of a rectangle one point at a time, either clockwise or counter-clockwise.
- Adds step size, a speed prescaler, valid/ready backpressure, lap counting, edge reporting and a configurable colour.
- Sits between the game logic and the pixel renderer.

Parameters:
- COORD_W, 8, width of the x/y coordinates.
- X_MIN, 5, left edge x.
- X_MAX, 105, right edge x (X_MAX > X_MIN).
- Y_MIN, 15, top edge y.
- Y_MAX, 115, bottom edge y (Y_MAX > Y_MIN).
- STEP, 1, coordinate increment per move (1 to the smaller span).
- DIV, 1, enabled cycles per move (DIV >= 1).
- LAP_W, 8, lap counter width.
- COLOR_W, 3, colour width.
- COLOR, 3'b010, constant colour presented with each point.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- en, in, 1, run enable.
- dir, in, 1, 0 = clockwise (screen y grows down), 1 = counter-clockwise.
- out_ready, in, 1, renderer accepts the current point.
- out_valid, out, 1, a point is presented.
- CounterX, out, COORD_W, current x.
- CounterY, out, COORD_W, current y.
- color, out, COLOR_W, point colour.
- edge_id, out, 2, current edge: 0 TOP, 1 RIGHT, 2 BOTTOM, 3 LEFT.
- lap_done, out, 1, one-cycle pulse on lap completion.
- lap_cnt, out, LAP_W, completed laps, wraps modulo 2^LAP_W.

Behaviour:
- Reset (rst = 0, asynchronous):
  - CounterX = X_MIN, CounterY = Y_MIN, edge_id = TOP.
  - div_cnt = 0, lap_cnt = 0, lap_done = 0, out_valid = 0.
  - color = COLOR.
- out_valid is registered as en. It goes to 1 one cycle after en rises.
- Prescaler div_cnt:
  - Counts only while en = 1.
  - A move fires when en = 1, div_cnt == DIV-1 and out_ready = 1. On a move, div_cnt returns to 0.
  - If div_cnt == DIV-1 and out_ready = 0, div_cnt holds (stall). Position does not change under backpressure.
  - en = 0 holds div_cnt and position.
- Move rule: advance along edge_id in the direction set by dir.
  - CW: TOP x+, RIGHT y+, BOTTOM x-, LEFT y-.
  - CCW: LEFT y+, BOTTOM x+, RIGHT y-, TOP x-.
  - The new coordinate saturates at the edge end: min(pos+STEP, MAX) or max(pos-STEP, MIN). Arithmetic uses COORD_W+1 bits, so there is no wrap.
- Corner turn:
  - If the position is already at the end of the current edge for the current dir, the move switches edge_id to the next edge (CW: +1 mod 4, CCW: -1 mod 4) and advances STEP along the new edge, in the same cycle.
  - Each corner is therefore presented exactly once per lap.
- Direction change:
  - dir is sampled at every move. A change mid-edge reverses travel along the same edge.
  - A change at a corner applies the corner rule with the new dir.
- Lap completion:
  - lap_done = 1 for the cycle after a move that lands on (X_MIN, Y_MIN); lap_cnt increments in the same cycle.
  - The reset position does not count as a lap.
- All outputs are registered. The position presented is the post-move position, one cycle after the move condition.
- Reset mid-operation returns to the reset state immediately, regardless of backpressure.

Decomposition:
- Shared package pong_pkg holds:
  - edge encodings E_TOP, E_RIGHT, E_BOTTOM, E_LEFT;
  - DIR_CW / DIR_CCW constants;
  - colour constants (COLOR_GREEN = 3'b010).
- One sub-module, tick_divider: the DIV prescaler with stall input. It produces the move strobe.

Test Plan:
- Defaults, en = 1, out_ready = 1, dir = 0:
  - after 100 moves the output is (105,15) with edge TOP;
  - move 101 gives (105,16) with edge RIGHT;
  - move 400 gives (5,15), lap_done pulses once and lap_cnt = 1.
- STEP = 30, CW: x sequence 35, 65, 95, 105, then (105,45), (105,75), (105,105), (105,115), then bottom starts at x = 75.
- Backpressure, DIV = 1: hold out_ready = 0 for 5 cycles at (20,15). Position and div_cnt stay frozen. Resuming out_ready gives (21,15) on the next cycle.
- Direction: at (50,15) switch dir to 1. The next move gives (49,15). Continuing reaches (5,15), then turns to (5,16) with edge LEFT.
- DIV = 4: exactly one move per 4 enabled cycles. Toggling en off for 3 cycles delays the next move by 3 cycles.
- Async reset: assert rst = 0 mid-cycle at (105,60). Outputs go to (5,15), edge TOP, lap_cnt = 0, out_valid = 0 without waiting for a clk edge.
